// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: size codes, arbiter state encodings and owner codes shared by the RAM arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_RD,
    ARB_WR,
    ARB_RMW_RD,
    ARB_RMW_WR
  } arb_state_e;
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_MEM = 1'b1;
  // Byte and half stores need read-modify-write; size 11 behaves as a word
  function automatic logic is_sub_word(input logic [1:0] size);
    return size < MEM_SIZE_W;
  endfunction
endpackage

// File: rtl/mem_arbiter_store_merge.sv
// store_merge: places right-aligned SB/SH store data into the addressed lane(s) of the old RAM word
module store_merge
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  output logic [DATA_W-1:0] merged_o
);
  // Bytes pick the lane from off[1:0], halves from off[1] only; words pass the store data through
  always_comb begin
    merged_o = old_i;
    if (size_i == MEM_SIZE_B) merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (size_i == MEM_SIZE_H) merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    else merged_o = wdata_i;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data RAM between fetch and memory-stage requesters,
// doing SB/SH as read-modify-write. Define MEM_ARB_RR_EN for round-robin on contention;
// without it MEM always beats IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_valid_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q, merged;
  logic              mem_wins, if_valid, mem_valid, mem_ld;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;
  assign mem_wins = mem_req_i & (~if_req_i | (last_q == OWNER_IF));
`else
  assign mem_wins = mem_req_i;
`endif
  store_merge #(.DATA_W(DATA_W)) u_store_merge (
    .old_i    (ram_rdata_i),
    .wdata_i  (mem_wdata_i),
    .size_i   (mem_size_i),
    .off_i    (mem_addr_i[1:0]),
    .merged_o (merged)
  );
  // Next state, grant and RAM command; a low reset abandons any access and idles every output
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef MEM_ARB_RR_EN
    last_d = last_q;
`endif
    ram_ce_o = 1'b0;
    ram_we_o = 1'b0;
    ram_addr_o = '0;
    ram_wdata_o = '0;
    if_valid = 1'b0;
    mem_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (mem_wins) begin
          ram_ce_o = 1'b1;
          ram_addr_o = mem_addr_i & WORD_MASK;
          ram_we_o = mem_we_i & ~is_sub_word(mem_size_i);
          ram_wdata_o = ram_we_o ? mem_wdata_i : '0;
          owner_d = OWNER_MEM;
          state_d = !mem_we_i ? ARB_RD : is_sub_word(mem_size_i) ? ARB_RMW_RD : ARB_WR;
        end else if (if_req_i) begin
          ram_ce_o = 1'b1;
          ram_addr_o = if_addr_i & WORD_MASK;
          owner_d = OWNER_IF;
          state_d = ARB_RD;
        end
`ifdef MEM_ARB_RR_EN
        if (mem_req_i | if_req_i) last_d = owner_d;
`endif
      end
      ARB_RD: begin
        if_valid = owner_q == OWNER_IF;
        mem_valid = owner_q == OWNER_MEM;
        state_d = ARB_IDLE;
      end
      ARB_WR: begin
        mem_valid = 1'b1;
        state_d = ARB_IDLE;
      end
      ARB_RMW_RD: begin
        ram_ce_o = 1'b1;
        ram_we_o = 1'b1;
        ram_addr_o = mem_addr_i & WORD_MASK;
        ram_wdata_o = merged;
        state_d = ARB_RMW_WR;
      end
      ARB_RMW_WR: begin
        mem_valid = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (!rst_i) begin
      state_d = ARB_IDLE;
      ram_ce_o = 1'b0;
      ram_we_o = 1'b0;
      ram_addr_o = '0;
      ram_wdata_o = '0;
      if_valid = 1'b0;
      mem_valid = 1'b0;
    end
  end
  assign mem_ld = mem_valid & (state_q == ARB_RD);
  assign if_valid_o = if_valid;
  assign mem_valid_o = mem_valid;
  assign if_rdata_o = !rst_i ? '0 : if_valid ? ram_rdata_i : if_rdata_q;
  assign mem_rdata_o = !rst_i ? '0 : mem_ld ? ram_rdata_i : mem_rdata_q;
  assign stall_if_o = rst_i & if_req_i & ~if_valid;
  assign stall_mem_o = rst_i & mem_req_i & ~mem_valid;
  // State and owner registers; read-data registers keep the last returned word between valids
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_IF;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (if_valid) if_rdata_q <= ram_rdata_i;
      if (mem_ld) mem_rdata_q <= ram_rdata_i;
    end
  end
`ifdef MEM_ARB_RR_EN
  // Last-grant register steering the next contended grant to the other requester
  always_ff @(posedge clk_i) begin
    if (!rst_i) last_q <= OWNER_IF;
    else last_q <= last_d;
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural one-cycle-latency RAM
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [1:0]  mem_size_i = 2'b10;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_valid_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic        stall_if_o, stall_mem_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_valid_o(mem_valid_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ram_ce_o && ram_we_o) ram[ram_addr_o[9:2]] <= ram_wdata_o;
    if (ram_ce_o && !ram_we_o) ram_rdata_i <= ram[ram_addr_o[9:2]];
  end

  localparam int K_RD = 0, K_WR = 1, K_IFV = 2, K_MEMV = 3;
  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_data;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  mon_k;
  logic [31:0] mon_a, mon_d;
  bit  mon_ok;
  int  n_cmp = 0, n_bad = 0;
  int  n;

  task automatic expect_ev(input int c, input int k, input logic [31:0] a, input logic [31:0] d, input bit cd);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    pre_we = 1'b1;
    pre_a = a[9:2];
    pre_d = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_valid(input bit is_if, input string nm);
    int i;
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (is_if ? if_valid_o : mem_valid_o) break;
    end
    if (i == 8) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no valid in 8 cycles, want valid", nm);
    end
  endtask

  task automatic if_issue(input logic [31:0] a, output int c);
    @(posedge clk);
    #1;
    if_req_i = 1'b1;
    if_addr_i = a;
    c = cyc;
  endtask

  task automatic mem_issue(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, output int c);
    @(posedge clk);
    #1;
    mem_req_i = 1'b1;
    mem_we_i = we;
    mem_size_i = sz;
    mem_addr_i = a;
    mem_wdata_i = d;
    c = cyc;
  endtask

  task automatic if_finish(input string nm);
    wait_valid(1'b1, nm);
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
  endtask

  task automatic mem_finish(input string nm);
    wait_valid(1'b0, nm);
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_i && (ram_ce_o || if_valid_o || mem_valid_o)) begin
          mon_k = ram_ce_o ? (ram_we_o ? K_WR : K_RD) : if_valid_o ? K_IFV : K_MEMV;
          mon_a = ram_addr_o;
          mon_d = ram_ce_o ? ram_wdata_o : if_valid_o ? if_rdata_o : mem_rdata_o;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got cyc %0d kind %0d addr %h data %h, want no event", cyc, mon_k, mon_a, mon_d);
          end else begin
            mon_e = exp_q.pop_front();
            mon_ok = mon_e.cyc == cyc && mon_e.kind == mon_k && (mon_k > K_WR || mon_e.addr == mon_a)
                     && (!(mon_k == K_WR || mon_e.chk_data) || mon_e.data == mon_d);
            if (!mon_ok) begin
              n_bad++;
              $display("FAIL sb_event: got cyc %0d kind %0d addr %h data %h, want cyc %0d kind %0d addr %h data %h",
                       cyc, mon_k, mon_a, mon_d, mon_e.cyc, mon_e.kind, mon_e.addr, mon_e.data);
            end
          end
        end
      end
    join_none

    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h200, 32'h11223344);
    preload(32'h104, 32'h00000000);
    preload(32'h108, 32'h11223344);
    preload(32'h204, 32'h55667788);
    preload(32'h300, 32'h00000000);
    @(negedge clk);
    chk("rst_ce", ram_ce_o, 0);
    chk("rst_we", ram_we_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_stall_if", stall_if_o, 0);
    chk("rst_stall_mem", stall_mem_o, 0);
    chk("rst_valids", {if_valid_o, mem_valid_o}, 0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 0);
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    rst_i = 1'b1;

    @(posedge clk);
    #1;
    if_req_i = 1'b1;
    if_addr_i = 32'h100;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_size_i = 2'b10;
    mem_addr_i = 32'h200;
    n = cyc;
    for (int g = 0; g < 8; g++) begin
`ifdef MEM_ARB_RR_EN
      bit w_mem = (g % 2) == 0;
`else
      bit w_mem = 1'b1;
`endif
      expect_ev(n + 2 * g, K_RD, w_mem ? 32'h200 : 32'h100, 0, 1'b0);
      expect_ev(n + 2 * g + 1, w_mem ? K_MEMV : K_IFV, 0, w_mem ? 32'h11223344 : 32'hDEADBEEF, 1'b1);
    end
    @(negedge clk);
    chk("cont_stall_if", stall_if_o, 1);
    chk("cont_stall_mem", stall_mem_o, 1);
    @(negedge clk);
    chk("cont_stall_mem_done", stall_mem_o, 0);
    repeat (n + 16 - cyc) @(posedge clk);
    #1;
    if_req_i = 1'b0;
    mem_req_i = 1'b0;

    if_issue(32'h100, n);
    expect_ev(n, K_RD, 32'h100, 0, 1'b0);
    expect_ev(n + 1, K_IFV, 0, 32'hDEADBEEF, 1'b1);
    if_finish("fetch");
    @(negedge clk);
    chk("if_rdata_hold", if_rdata_o, 32'hDEADBEEF);

    mem_issue(1'b1, 2'b00, 32'h202, 32'hFFFFFFAB, n);
    expect_ev(n, K_RD, 32'h200, 0, 1'b0);
    expect_ev(n + 1, K_WR, 32'h200, 32'h11AB3344, 1'b0);
    expect_ev(n + 2, K_MEMV, 0, 0, 1'b0);
    mem_finish("sb");

    mem_issue(1'b0, 2'b10, 32'h200, 0, n);
    expect_ev(n, K_RD, 32'h200, 0, 1'b0);
    expect_ev(n + 1, K_MEMV, 0, 32'h11AB3344, 1'b1);
    mem_finish("ld_sb");
    @(negedge clk);
    chk("mem_rdata_hold", mem_rdata_o, 32'h11AB3344);

    mem_issue(1'b1, 2'b01, 32'h107, 32'h0000CAFE, n);
    expect_ev(n, K_RD, 32'h104, 0, 1'b0);
    expect_ev(n + 1, K_WR, 32'h104, 32'hCAFE0000, 1'b0);
    expect_ev(n + 2, K_MEMV, 0, 0, 1'b0);
    mem_finish("sh_hi");

    mem_issue(1'b1, 2'b01, 32'h109, 32'hA5A5BEEF, n);
    expect_ev(n, K_RD, 32'h108, 0, 1'b0);
    expect_ev(n + 1, K_WR, 32'h108, 32'h1122BEEF, 1'b0);
    expect_ev(n + 2, K_MEMV, 0, 0, 1'b0);
    mem_finish("sh_lo");

    mem_issue(1'b1, 2'b10, 32'h303, 32'h12345678, n);
    expect_ev(n, K_WR, 32'h300, 32'h12345678, 1'b0);
    expect_ev(n + 1, K_MEMV, 0, 0, 1'b0);
    expect_ev(n + 2, K_RD, 32'h100, 0, 1'b0);
    expect_ev(n + 3, K_IFV, 0, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1;
    if_req_i = 1'b1;
    if_addr_i = 32'h100;
    @(negedge clk);
    chk("sw_no_grant", ram_ce_o, 0);
    chk("sw_valid", mem_valid_o, 1);
    chk("sw_stall_if", stall_if_o, 1);
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
    if_finish("sw_fetch");

    mem_issue(1'b0, 2'b11, 32'h300, 0, n);
    expect_ev(n, K_RD, 32'h300, 0, 1'b0);
    expect_ev(n + 1, K_MEMV, 0, 32'h12345678, 1'b1);
    mem_finish("ld_sw");

    mem_issue(1'b1, 2'b00, 32'h204, 32'h00000012, n);
    expect_ev(n, K_RD, 32'h204, 0, 1'b0);
    expect_ev(n + 1, K_WR, 32'h204, 32'h55667712, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rmw_rst_we", ram_we_o, 0);
    chk("rmw_rst_ce", ram_ce_o, 0);
    chk("rmw_rst_valid", mem_valid_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    mem_req_i = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = 32'h204;
    expect_ev(cyc, K_RD, 32'h204, 0, 1'b0);
    expect_ev(cyc + 1, K_IFV, 0, 32'h55667712, 1'b1);
    if_finish("post_rst_fetch");

    repeat (2) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
